wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 143 ++++++++++++++
 tb/tb_wb_queue.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// wb_queue: writeback queue in front of a register file.
//
// Entries {regsel, data} are queued in arrival order. The head is presented
// on the write port every cycle the queue is non-empty. The register file
// always accepts that write, so the head pops on every such edge.
//
// Optional bypass lookup: define WB_QUEUE_BYPASS_EN to compile it in. In the
// default build hit1/hit2/hit1data/hit2data are tied to 0 and look1sel and
// look2sel are ignored.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   in_valid/in_ready         producer handshake
//   in_regsel/in_data         entry offered by the producer
//   write/writeregsel/writedata  register file write port (head entry)
//   look1sel/look2sel         bypass lookup indices
//   hit1/hit2, hit1data/hit2data  lookup results (newest matching entry)
//   count                     number of occupied entries
module wb_queue #(
  parameter int DEPTH     = 4,
  parameter int BIT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_regsel,
  input  logic [BIT_WIDTH-1:0]   in_data,
  output logic                   write,
  output logic [2:0]             writeregsel,
  output logic [BIT_WIDTH-1:0]   writedata,
  input  logic [2:0]             look1sel,
  input  logic [2:0]             look2sel,
  output logic                   hit1,
  output logic                   hit2,
  output logic [BIT_WIDTH-1:0]   hit1data,
  output logic [BIT_WIDTH-1:0]   hit2data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2:0]           regsel_mem_q [DEPTH];
  logic [2:0]           regsel_mem_d [DEPTH];
  logic [BIT_WIDTH-1:0] data_mem_q   [DEPTH];
  logic [BIT_WIDTH-1:0] data_mem_d   [DEPTH];

  logic push;
  logic pop;

  // Ready depends only on registered occupancy; no pass-through when full.
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count_q != '0);
  assign write    = pop;
  assign count    = count_q;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    regsel_mem_d = regsel_mem_q;
    data_mem_d   = data_mem_q;
    if (push) begin
      regsel_mem_d[tail_q] = in_regsel;
      data_mem_d[tail_q]   = in_data;
      tail_d               = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not cleared by reset; a reset edge simply drops any push
  // and forgets pending entries by zeroing the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      regsel_mem_q <= regsel_mem_d;
      data_mem_q   <= data_mem_d;
    end
  end

  always_comb begin
    writeregsel = '0;
    writedata   = '0;
    if (pop) begin
      writeregsel = regsel_mem_q[head_q];
      writedata   = data_mem_q[head_q];
    end
  end

`ifdef WB_QUEUE_BYPASS_EN
  logic [PW-1:0] lk_idx;

  // Walk occupied slots from head toward tail; later matches overwrite
  // earlier ones so the newest matching entry wins. The head is included
  // even though it is being written this cycle; same-cycle in_data is not.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    hit1data = '0;
    hit2data = '0;
    lk_idx   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (regsel_mem_q[lk_idx] == look1sel) begin
          hit1     = 1'b1;
          hit1data = data_mem_q[lk_idx];
        end
        if (regsel_mem_q[lk_idx] == look2sel) begin
          hit2     = 1'b1;
          hit2data = data_mem_q[lk_idx];
        end
      end
    end
  end
`else
  logic unused_look;
  assign unused_look = ^{look1sel, look2sel};
  assign hit1     = 1'b0;
  assign hit2     = 1'b0;
  assign hit1data = '0;
  assign hit2data = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int BW    = 16;
`ifdef WB_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_regsel;
  logic [BW-1:0] in_data;
  logic          write;
  logic [2:0]    writeregsel;
  logic [BW-1:0] writedata;
  logic [2:0]    look1sel;
  logic [2:0]    look2sel;
  logic          hit1;
  logic          hit2;
  logic [BW-1:0] hit1data;
  logic [BW-1:0] hit2data;
  logic [2:0]    count;

  wb_queue #(.DEPTH(DEPTH), .BIT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regsel(in_regsel), .in_data(in_data),
    .write(write), .writeregsel(writeregsel), .writedata(writedata),
    .look1sel(look1sel), .look2sel(look2sel),
    .hit1(hit1), .hit2(hit2), .hit1data(hit1data), .hit2data(hit2data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;
  bit mon_popped = 1'b0;

  // Scoreboard: accepted entries in order, oldest first, not yet seen on the write port.
  logic [18:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void lookup(input logic [2:0] sel, output logic h, output logic [BW-1:0] d);
    h = 1'b0;
    d = '0;
    foreach (exp_q[i]) begin
      if (exp_q[i][18:16] == sel) begin
        h = 1'b1;
        d = exp_q[i][15:0];
      end
    end
    if (!BYP) begin
      h = 1'b0;
      d = '0;
    end
  endfunction

  // Reference model: accept when occupancy (including the entry being
  // written this cycle) is below DEPTH; reset forgets everything.
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else if (in_valid && (exp_q.size() + int'(mon_popped)) < DEPTH) begin
      exp_q.push_back({in_regsel, in_data});
    end
    mon_popped = 1'b0;
  end

  // Monitor: compare every visible output mid-cycle, pop on each write.
  always @(negedge clk) begin
    int n;
    logic h1, h2;
    logic [BW-1:0] d1, d2;
    if (mon_en) begin
      n = exp_q.size();
      chk("count", 32'(count), 32'(n));
      chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
      chk("write", 32'(write), 32'(n != 0));
      lookup(look1sel, h1, d1);
      lookup(look2sel, h2, d2);
      chk("hit1", 32'(hit1), 32'(h1));
      chk("hit1data", 32'(hit1data), 32'(d1));
      chk("hit2", 32'(hit2), 32'(h2));
      chk("hit2data", 32'(hit2data), 32'(d2));
      if (n != 0) begin
        chk("writeregsel", 32'(writeregsel), 32'(exp_q[0][18:16]));
        chk("writedata", 32'(writedata), 32'(exp_q[0][15:0]));
        void'(exp_q.pop_front());
        mon_popped = 1'b1;
      end else begin
        chk("writeregsel_idle", 32'(writeregsel), 32'd0);
        chk("writedata_idle", 32'(writedata), 32'd0);
      end
    end
  end

  task automatic step(input logic v, input logic [2:0] rs, input logic [BW-1:0] d,
                      input logic [2:0] l1, input logic [2:0] l2, input logic r);
    in_valid  = v;
    in_regsel = rs;
    in_data   = d;
    look1sel  = l1;
    look2sel  = l2;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_regsel = '0; in_data = '0;
    look1sel = '0; look2sel = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    // Post-reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_hit1", 32'(hit1), 32'd0);
    chk("rst_hit2data", 32'(hit2data), 32'd0);

    // Single push, one-cycle latency
    step(1'b1, 3'd3, 16'h1234, 3'd0, 3'd0, 1'b1);
    chk("lat_write", 32'(write), 32'd1);
    chk("lat_regsel", 32'(writeregsel), 32'd3);
    chk("lat_data", 32'(writedata), 32'h1234);
    step(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);
    chk("drain_write", 32'(write), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // Back-to-back pushes with drain active, incl. same index repeated
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i < 2) ? 3'd2 : 3'(i), 16'(16'h100 + i), 3'd2, 3'd4, 1'b1);
      chk("b2b_count_le1", 32'(count <= 3'd1), 32'd1);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
    end
    step(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);

    // Bypass: same index pushed twice, lookups on hit and miss index
    step(1'b1, 3'd5, 16'hAAAA, 3'd5, 3'd6, 1'b1);
    chk("byp_hit1_a", 32'(hit1), 32'(BYP));
    chk("byp_hit1data_a", 32'(hit1data), BYP ? 32'hAAAA : 32'd0);
    step(1'b1, 3'd5, 16'hBBBB, 3'd5, 3'd6, 1'b1);
    chk("byp_hit1_b", 32'(hit1), 32'(BYP));
    chk("byp_hit1data_b", 32'(hit1data), BYP ? 32'hBBBB : 32'd0);
    chk("byp_hit2", 32'(hit2), 32'd0);
    chk("byp_hit2data", 32'(hit2data), 32'd0);
    // Index 0 is an ordinary index
    step(1'b1, 3'd0, 16'h0C0C, 3'd0, 3'd5, 1'b1);
    chk("byp_idx0_hit", 32'(hit1), 32'(BYP));
    chk("byp_idx0_data", 32'(hit1data), BYP ? 32'h0C0C : 32'd0);

    // Reset mid-operation with a push offered on the reset edge
    step(1'b1, 3'd1, 16'h1111, 3'd1, 3'd2, 1'b1);
    step(1'b1, 3'd2, 16'h2222, 3'd1, 3'd2, 1'b1);
    step(1'b1, 3'd4, 16'h4444, 3'd1, 3'd4, 1'b0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_write", 32'(write), 32'd0);
    step(1'b0, 3'd0, 16'h0, 3'd4, 3'd1, 1'b1);
    chk("midrst_write2", 32'(write), 32'd0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)), 16'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0);
    end
    step(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);
    step(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1);
    chk("final_empty", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
